// File: rtl/store_buffer.sv
// Posted-write buffer between MEM and dm: stores are accepted in the same cycle and drained in idle cycles, and loads are forwarded with zero latency.
// Backpressure: stall_o asserts for one cycle on a store while full, and the head drains in that same cycle.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 7,
    parameter int DW    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     memRead_i,
    input  logic                     memWrite_i,
    input  logic [AW-1:0]            addr_i,
    input  logic [DW-1:0]            wData_i,
    output logic [DW-1:0]            rData_o,
    output logic                     stall_o,
    output logic [AW-1:0]            dmAddr_o,
    output logic                     dmMemRead_o,
    output logic                     dmMemWrite_o,
    output logic [DW-1:0]            dmWData_o,
    input  logic [DW-1:0]            dmRData_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_push;
    logic          w_load;
    logic          w_drain;
    logic          w_hit;
    logic [DW-1:0] w_hit_data;
    logic [PW-1:0] w_idx;

    assign w_full  = (r_count == FULL_CNT);
    assign stall_o = !rst_i && memWrite_i && w_full;
    assign w_push  = !rst_i && memWrite_i && !w_full;
    // A simultaneous read+write is treated as a store, so the load path ignores it.
    assign w_load  = !rst_i && memRead_i && !memWrite_i;
    assign w_drain = !rst_i && (r_count != '0) && ((!memRead_i && !memWrite_i) || stall_o);
    assign count_o = r_count;

    // Walk from oldest to youngest so the last match found is the youngest.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        w_idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if ((CW'(i) < r_count) && (r_addr[w_idx] == addr_i)) begin
                w_hit      = 1'b1;
                w_hit_data = r_data[w_idx];
            end
        end
    end

    always_comb begin
        rData_o      = '0;
        dmAddr_o     = '0;
        dmWData_o    = '0;
        dmMemRead_o  = 1'b0;
        dmMemWrite_o = 1'b0;
        if (w_drain) begin
            dmMemWrite_o = 1'b1;
            dmAddr_o     = r_addr[r_head];
            dmWData_o    = r_data[r_head];
        end else if (w_load) begin
            if (w_hit) begin
                rData_o = w_hit_data;
            end else begin
                dmMemRead_o = 1'b1;
                dmAddr_o    = addr_i;
                rData_o     = dmRData_i;
            end
        end
    end

    // Push and drain are mutually exclusive: draining requires the port to be idle or stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_push) begin
            r_tail  <= r_tail + PW'(1);
            r_count <= r_count + CW'(1);
        end else if (w_drain) begin
            r_head  <= r_head + PW'(1);
            r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_addr[r_tail] <= addr_i;
            r_data[r_tail] <= wData_i;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: a dm model, an architectural memory reference, and scoreboards for dm writes and load data.
module tb_store_buffer;

    typedef struct packed {
        logic [6:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        mr;
    logic        mw;
    logic [6:0]  addr;
    logic [31:0] wd;
    logic [31:0] rData_o;
    logic        stall_o;
    logic [6:0]  dmAddr_o;
    logic        dmMemRead_o;
    logic        dmMemWrite_o;
    logic [31:0] dmWData_o;
    logic [31:0] dmRData_i;
    logic [2:0]  count_o;

    logic [31:0] dm      [128];
    logic [31:0] ref_mem [128];
    wr_t         exp_wr [$];
    logic [31:0] exp_ld [$];

    int n_vec;
    int n_miss;

    store_buffer #(.DEPTH(4), .AW(7), .DW(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .memRead_i    (mr),
        .memWrite_i   (mw),
        .addr_i       (addr),
        .wData_i      (wd),
        .rData_o      (rData_o),
        .stall_o      (stall_o),
        .dmAddr_o     (dmAddr_o),
        .dmMemRead_o  (dmMemRead_o),
        .dmMemWrite_o (dmMemWrite_o),
        .dmWData_o    (dmWData_o),
        .dmRData_i    (dmRData_i),
        .count_o      (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dmRData_i = dm[dmAddr_o];
    always @(posedge clk) begin
        if (dmMemWrite_o) dm[dmAddr_o] <= dmWData_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Every dm write must match the oldest outstanding accepted store.
    always @(negedge clk) begin : mon
        wr_t e;
        if (dmMemWrite_o) begin
            if (exp_wr.size() == 0) begin
                chk("unexp_wr", 32'(dmMemWrite_o), 32'd0);
            end else begin
                e = exp_wr.pop_front();
                chk("wr_addr", 32'(dmAddr_o), 32'(e.a));
                chk("wr_data", dmWData_o, e.d);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [6:0] a, input logic [31:0] d, input int exp_stalls);
        int stalls;
        stalls = 0;
        mr = 1'b0; mw = 1'b1; addr = a; wd = d;
        #1;
        while (stall_o && stalls < 4) begin
            chk("stall_drain", 32'(dmMemWrite_o), 32'd1);
            stalls++;
            step();
        end
        chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
        exp_wr.push_back('{a, d});
        ref_mem[a] = d;
        step();
        mw = 1'b0; addr = '0; wd = '0;
    endtask

    task automatic do_load(input logic [6:0] a, input logic exp_dmrd);
        mr = 1'b1; mw = 1'b0; addr = a; wd = '0;
        exp_ld.push_back(ref_mem[a]);
        #1;
        chk("ld_data", rData_o, exp_ld.pop_front());
        chk("ld_dmrd", 32'(dmMemRead_o), 32'(exp_dmrd));
        if (exp_dmrd) chk("ld_dmaddr", 32'(dmAddr_o), 32'(a));
        chk("ld_nowr", 32'(dmMemWrite_o), 32'd0);
        chk("ld_stall", 32'(stall_o), 32'd0);
        step();
        mr = 1'b0; addr = '0;
    endtask

    task automatic do_idle(input logic exp_drain);
        mr = 1'b0; mw = 1'b0; addr = '0; wd = '0;
        #1;
        chk("idle_drain", 32'(dmMemWrite_o), 32'(exp_drain));
        chk("idle_dmrd", 32'(dmMemRead_o), 32'd0);
        step();
    endtask

    task automatic chk_cnt(input int exp);
        chk("count", 32'(count_o), 32'(exp));
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        for (int i = 0; i < 128; i++) begin
            dm[i]      = 32'hD000_0000 | 32'(i);
            ref_mem[i] = 32'hD000_0000 | 32'(i);
        end
        rst = 1'b1; mr = 1'b1; mw = 1'b0; addr = 7'd4; wd = '0;
        #2;
        chk("rst_dmrd", 32'(dmMemRead_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; mr = 1'b0; addr = '0;
        #1;
        chk_cnt(0);
        chk("post_rst_rdata", rData_o, 32'd0);
        chk("post_rst_dmaddr", 32'(dmAddr_o), 32'd0);
        chk("post_rst_dmwdata", dmWData_o, 32'd0);
        chk("post_rst_dmwr", 32'(dmMemWrite_o), 32'd0);
        chk("post_rst_dmrd", 32'(dmMemRead_o), 32'd0);
        chk("post_rst_stall", 32'(stall_o), 32'd0);

        // Single store then drain
        do_store(7'd5, 32'hAAAA_0001, 0);
        chk_cnt(1);
        #1;
        chk("t1_dmwr", 32'(dmMemWrite_o), 32'd1);
        chk("t1_dmaddr", 32'(dmAddr_o), 32'd5);
        chk("t1_dmwdata", dmWData_o, 32'hAAAA_0001);
        step();
        chk_cnt(0);

        // Forwarding from the youngest of two same-address entries
        do_store(7'd9, 32'h11, 0);
        do_store(7'd9, 32'h22, 0);
        do_load(7'd9, 1'b0);
        do_idle(1'b1);
        do_idle(1'b1);
        chk("t2_dm9", dm[9], 32'h22);
        chk_cnt(0);

        // Load miss reads dm
        do_store(7'd3, 32'h33, 0);
        do_load(7'd4, 1'b1);
        do_idle(1'b1);
        chk_cnt(0);

        // Full: one-cycle stall, then drain with pointer wrap
        for (int i = 0; i < 4; i++) do_store(7'(i), 32'h100 + 32'(i), 0);
        chk_cnt(4);
        do_store(7'd7, 32'h77, 1);
        chk_cnt(4);
        for (int i = 0; i < 4; i++) do_idle(1'b1);
        chk_cnt(0);
        do_idle(1'b0);

        // Back-to-back loads starve the drain
        do_store(7'd20, 32'hBEEF_0020, 0);
        do_store(7'd21, 32'hBEEF_0021, 0);
        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 0)      do_load(7'd20, 1'b0);
            else if (i % 3 == 1) do_load(7'd21, 1'b0);
            else                 do_load(7'(50 + i), 1'b1);
            chk_cnt(2);
        end
        do_idle(1'b1);
        do_idle(1'b1);
        chk_cnt(0);

        // Reset discards pending stores
        do_store(7'd40, 32'hCAFE_0040, 0);
        do_store(7'd41, 32'hCAFE_0041, 0);
        do_store(7'd42, 32'hCAFE_0042, 0);
        chk_cnt(3);
        rst = 1'b1;
        exp_wr.delete();
        for (int a = 40; a < 43; a++) ref_mem[a] = 32'hD000_0000 | 32'(a);
        #1;
        chk("t6_rst_dmwr", 32'(dmMemWrite_o), 32'd0);
        chk("t6_rst_stall", 32'(stall_o), 32'd0);
        step();
        rst = 1'b0;
        chk_cnt(0);
        do_idle(1'b0);
        do_load(7'd41, 1'b1);

        for (int a = 0; a < 128; a++) chk("dm_final", dm[a], ref_mem[a]);
        chk("wr_left", 32'(exp_wr.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
